// File: rtl/accumulate_engine.sv
// In-place scan (wrap sum / saturating sum / max / min) over a window of a single-port array.
// Host takes the array port with controlArr; the engine then holds state until it gets the port back.
module accumulate_engine #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int LENW  = 11,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_enable,
  input  logic [AW-1:0]    init_base,
  input  logic [LENW-1:0]  init_len,
  input  logic [WIDTH-1:0] init_acc,
  input  logic [1:0]       mode,
  output logic             w_enable,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  input  logic             controlArr,
  input  logic             controlArrWEnable_a,
  input  logic [AW-1:0]    controlArrAddr_a,
  input  logic [WIDTH-1:0] controlArrWData_a,
  output logic [WIDTH-1:0] controlArrRData_a
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_AC   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [AW-1:0]    addr;
  logic [LENW-1:0]  len;
  logic [LENW-1:0]  idx;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_mode;
  logic             ac_fresh;
  logic [WIDTH-1:0] x_hold;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] op_val;
  logic [WIDTH:0]   wide_sum;

  // A stalled AC loses its read data to host reads, so the operand is parked in x_hold.
  assign x = ac_fresh ? controlArrRData_a : x_hold;

  always_comb begin
    wide_sum = {acc[WIDTH-1], acc} + {x[WIDTH-1], x};
    op_val   = acc + x;
    case (op_mode)
      2'd1: begin
        if (wide_sum[WIDTH] != wide_sum[WIDTH-1])
          op_val = wide_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
          op_val = wide_sum[WIDTH-1:0];
      end
      2'd2: op_val = ($signed(x) > $signed(acc)) ? x : acc;
      2'd3: op_val = ($signed(x) < $signed(acc)) ? x : acc;
      default: op_val = acc + x;
    endcase
  end

  always_comb begin
    mem_addr  = addr;
    mem_we    = (state == S_AC);
    mem_wdata = op_val;
    if (controlArr) begin
      mem_addr  = controlArrAddr_a;
      mem_we    = controlArrWEnable_a;
      mem_wdata = controlArrWData_a;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      controlArrRData_a <= '0;
    else
      controlArrRData_a <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      len      <= '0;
      idx      <= '0;
      acc      <= '0;
      op_mode  <= 2'd0;
      ac_fresh <= 1'b0;
      x_hold   <= '0;
      result   <= '0;
      busy     <= 1'b0;
      w_enable <= 1'b0;
    end else begin
      w_enable <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (r_enable) begin
            addr    <= init_base;
            len     <= init_len;
            acc     <= init_acc;
            op_mode <= mode;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= (init_len == '0) ? S_DONE : S_RD;
          end
        end
        S_RD: begin
          if (!controlArr) begin
            ac_fresh <= 1'b1;
            state    <= S_AC;
          end
        end
        S_AC: begin
          if (!controlArr) begin
            acc      <= op_val;
            addr     <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
            idx      <= idx + 1'b1;
            ac_fresh <= 1'b0;
            state    <= (idx == len - 1'b1) ? S_DONE : S_RD;
          end else if (ac_fresh) begin
            x_hold   <= controlArrRData_a;
            ac_fresh <= 1'b0;
          end
        end
        default: begin
          result <= acc;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_engine.sv
// Bench for accumulate_engine: operator table, directed corner sequences, randomized runs vs a model.
module tb_accumulate_engine;

  localparam int W  = 64;
  localparam int D  = 1024;
  localparam int LW = 11;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r_enable;
  logic [AW-1:0] init_base;
  logic [LW-1:0] init_len;
  logic [W-1:0]  init_acc;
  logic [1:0]    mode;
  logic          w_enable;
  logic [W-1:0]  result;
  logic          busy;
  logic          controlArr;
  logic          controlArrWEnable_a;
  logic [AW-1:0] controlArrAddr_a;
  logic [W-1:0]  controlArrWData_a;
  logic [W-1:0]  controlArrRData_a;

  accumulate_engine #(.WIDTH(W), .DEPTH(D), .LENW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_base(init_base),
    .init_len(init_len), .init_acc(init_acc), .mode(mode), .w_enable(w_enable),
    .result(result), .busy(busy), .controlArr(controlArr),
    .controlArrWEnable_a(controlArrWEnable_a), .controlArrAddr_a(controlArrAddr_a),
    .controlArrWData_a(controlArrWData_a), .controlArrRData_a(controlArrRData_a)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] ref_mem [D];

  localparam logic [W-1:0] MAXP = 64'h7fff_ffff_ffff_ffff;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] x;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] x);
    logic signed [W+1:0] sa, sx, s, hi, lo;
    sa = $signed(a);
    sx = $signed(x);
    s  = sa + sx;
    hi = $signed({2'b00, MAXP});
    lo = $signed({2'b11, MINN});
    case (m)
      2'd0: return a + x;
      2'd1: begin
        if (s > hi) return MAXP;
        if (s < lo) return MINN;
        return s[W-1:0];
      end
      2'd2: return (sx > sa) ? x : a;
      default: return (sx < sa) ? x : a;
    endcase
  endfunction

  function automatic logic [W-1:0] model_run(input int base, input int len,
                                             input logic [W-1:0] a, input logic [1:0] m);
    for (int k = 0; k < len; k++) begin
      a = model_op(m, a, ref_mem[(base + k) % D]);
      ref_mem[(base + k) % D] = a;
    end
    return a;
  endfunction

  task automatic host_write(input int a, input logic [W-1:0] d);
    controlArr = 1'b1;
    controlArrWEnable_a = 1'b1;
    controlArrAddr_a = AW'(a);
    controlArrWData_a = d;
    @(posedge clk); #1;
    controlArrWEnable_a = 1'b0;
    controlArr = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_read(input int a, output logic [W-1:0] d);
    controlArr = 1'b1;
    controlArrWEnable_a = 1'b0;
    controlArrAddr_a = AW'(a);
    @(posedge clk); #1;
    d = controlArrRData_a;
    controlArr = 1'b0;
  endtask

  // Returns the cycle (start = 0) at which w_enable is seen, or -1 on timeout.
  task automatic run(input int base, input int len, input logic [W-1:0] a, input logic [1:0] m,
                     input int stall_at, input int stall_len, input int dup_at, output int lat);
    int cnt;
    r_enable = 1'b1;
    init_base = AW'(base);
    init_len = LW'(len);
    init_acc = a;
    mode = m;
    @(posedge clk); #1;
    r_enable = 1'b0;
    cnt = 1;
    if (len != 0) check("busy_after_start", {63'd0, busy}, 64'd1);
    while (!w_enable && cnt < 4000) begin
      controlArr = (cnt >= stall_at && cnt < stall_at + stall_len);
      r_enable = (cnt == dup_at);
      if (r_enable) begin
        init_base = AW'(base + 7);
        init_len = LW'(0);
        init_acc = 64'hdead;
        mode = 2'd2;
      end
      @(posedge clk); #1;
      cnt++;
    end
    controlArr = 1'b0;
    r_enable = 1'b0;
    lat = w_enable ? cnt : -1;
    if (w_enable) check("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] d, exp;
    int base, len, sat, sln;
    logic [1:0] m;
    logic [W-1:0] a;

    vecs[0] = '{2'd1, MINN, 64'hffff_ffff_ffff_ffff, MINN};
    vecs[1] = '{2'd0, MINN, 64'hffff_ffff_ffff_ffff, MAXP};
    vecs[2] = '{2'd1, 64'd100, -64'sd300, -64'sd200};
    vecs[3] = '{2'd2, -64'sd5, -64'sd3, -64'sd3};
    vecs[4] = '{2'd3, -64'sd5, -64'sd3, -64'sd5};
    vecs[5] = '{2'd2, MAXP, 64'hffff_ffff_ffff_ffff, MAXP};
    vecs[6] = '{2'd3, 64'd1, MINN, MINN};
    vecs[7] = '{2'd0, 64'hffff_ffff_ffff_ffff, 64'd1, 64'd0};
    vecs[8] = '{2'd1, MAXP, 64'd5, MAXP};

    rst_n = 1'b0;
    r_enable = 1'b0; init_base = '0; init_len = '0; init_acc = '0; mode = 2'd0;
    controlArr = 1'b0; controlArrWEnable_a = 1'b0; controlArrAddr_a = '0; controlArrWData_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_enable", {63'd0, w_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_rdata", controlArrRData_a, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Prefix sum of 1..10
    for (int i = 0; i < 10; i++) host_write(i, W'(i + 1));
    run(0, 10, 64'd0, 2'd0, 0, 0, 0, lat);
    check("t1_latency", W'(lat), 64'd22);
    check("t1_result", result, 64'd55);
    for (int i = 0; i < 10; i++) begin
      host_read(i, d);
      check("t1_readback", d, W'((i + 1) * (i + 2) / 2));
    end

    for (int v = 0; v < 9; v++) begin
      host_write(200, vecs[v].x);
      run(200, 1, vecs[v].a, vecs[v].m, 0, 0, 0, lat);
      check("tbl_latency", W'(lat), 64'd4);
      check("tbl_result", result, vecs[v].exp);
      host_read(200, d);
      check("tbl_writeback", d, vecs[v].exp);
    end

    // Saturating vs wrapping overflow
    host_write(0, 64'h4000_0000_0000_0000);
    host_write(1, 64'h4000_0000_0000_0000);
    run(0, 2, 64'd0, 2'd1, 0, 0, 0, lat);
    check("t2_sat_result", result, MAXP);
    host_read(1, d);
    check("t2_sat_arr1", d, MAXP);
    host_write(0, 64'h4000_0000_0000_0000);
    host_write(1, 64'h4000_0000_0000_0000);
    run(0, 2, 64'd0, 2'd0, 0, 0, 0, lat);
    check("t2_wrap_result", result, MINN);

    // Max then min scans over {5,-7,9,3}
    host_write(100, 64'd5); host_write(101, -64'sd7); host_write(102, 64'd9); host_write(103, 64'd3);
    run(100, 4, 64'd0, 2'd2, 0, 0, 0, lat);
    check("t3_max_result", result, 64'd9);
    host_read(101, d); check("t3_max_arr1", d, 64'd5);
    host_read(103, d); check("t3_max_arr3", d, 64'd9);
    host_write(100, 64'd5); host_write(101, -64'sd7); host_write(102, 64'd9); host_write(103, 64'd3);
    run(100, 4, 64'd0, 2'd3, 0, 0, 0, lat);
    check("t3_min_result", result, -64'sd7);
    host_read(100, d); check("t3_min_arr0", d, 64'd0);
    host_read(103, d); check("t3_min_arr3", d, -64'sd7);

    // Window wrapping past the top of the array
    for (int i = 0; i < 4; i++) host_write((D - 2 + i) % D, 64'd1);
    run(D - 2, 4, 64'd10, 2'd0, 0, 0, 0, lat);
    check("t4_result", result, 64'd14);
    host_read(D - 2, d); check("t4_top0", d, 64'd11);
    host_read(D - 1, d); check("t4_top1", d, 64'd12);
    host_read(0, d);     check("t4_idx0", d, 64'd13);
    host_read(1, d);     check("t4_idx1", d, 64'd14);

    // Empty window, stall, and ignored restart
    run(5, 0, 64'h1234, 2'd0, 0, 0, 0, lat);
    check("t5_len0_latency", W'(lat), 64'd2);
    check("t5_len0_result", result, 64'h1234);
    for (int i = 0; i < 3; i++) host_write(300 + i, W'(i + 1));
    run(300, 3, 64'd0, 2'd0, 3, 5, 0, lat);
    check("t5_stall_latency", W'(lat), 64'd13);
    check("t5_stall_result", result, 64'd6);
    host_read(302, d); check("t5_stall_arr", d, 64'd6);
    for (int i = 0; i < 3; i++) host_write(300 + i, W'(i + 1));
    run(300, 3, 64'd100, 2'd0, 0, 0, 4, lat);
    check("t5_dup_latency", W'(lat), 64'd8);
    check("t5_dup_result", result, 64'd106);

    // Reset mid-run
    for (int i = 0; i < 6; i++) host_write(400 + i, W'(i + 1));
    r_enable = 1'b1; init_base = AW'(400); init_len = LW'(6); init_acc = 64'd0; mode = 2'd0;
    @(posedge clk); #1;
    r_enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_w_enable", {63'd0, w_enable}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) host_write(400 + i, W'(i + 1));
    run(400, 6, 64'd0, 2'd0, 0, 0, 0, lat);
    check("t6_clean_latency", W'(lat), 64'd14);
    check("t6_clean_result", result, 64'd21);

    // Randomized runs against the model
    for (int it = 0; it < 40; it++) begin
      base = $urandom_range(0, D - 1);
      len  = $urandom_range(1, 40);
      m    = 2'($urandom_range(0, 3));
      a    = {$urandom, $urandom};
      for (int k = 0; k < len; k++) host_write((base + k) % D, {$urandom, $urandom});
      sat = 0; sln = 0;
      if ($urandom_range(0, 2) == 0) begin
        sat = $urandom_range(1, 2 * len);
        sln = $urandom_range(1, 4);
      end
      exp = model_run(base, len, a, m);
      run(base, len, a, m, sat, sln, 0, lat);
      check("rnd_latency", W'(lat), W'(2 * len + 2 + sln));
      check("rnd_result", result, exp);
      host_read(base, d);
      check("rnd_first", d, ref_mem[base]);
      host_read((base + len - 1) % D, d);
      check("rnd_last", d, ref_mem[(base + len - 1) % D]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
